// File: rtl/mpe_seq_pkg.sv
// Shared types and sizing for the MPE weight sequencer.
// Sizing defaults to a 3x3 kernel of 8-bit weights.
package mpe_seq_pkg;

    function automatic int clog2w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int BIN_LEN      = 8;
    localparam int KH           = 3;
    localparam int KW           = 3;

    localparam int MAX_INFLIGHT = 4;
    localparam int KSIZE        = KH * KW;
    localparam int IDX_W        = clog2w(KSIZE);
    localparam int INF_W        = clog2w(MAX_INFLIGHT + 1);
    localparam int ROW_W        = clog2w(KH);
    localparam int COL_W        = clog2w(KW);
    localparam int ENTRY_W      = BIN_LEN + 1;

    typedef enum logic [2:0] {
        IDLE,
        READY,
        ISSUE,
        FLUSH,
        DONE
    } state_t;

    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/mpe_kernel_buffer.sv
// Kernel weight store: KSIZE entries of {abs, magnitude}, one synchronous write port
// and one combinational read port.
module mpe_kernel_buffer
    import mpe_seq_pkg::*;
(
    input  logic               clock,
    input  logic               wr_en,
    input  idx_t               wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  idx_t               rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem [KSIZE];

    // NOTE: storage is deliberately not reset; contents are always reloaded before use.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mpe_weight_sequencer.sv
// Loads one kernel over valid/ready and streams it to an MPE with flow control.
// Define ZERO_SKIP_EN to skip zero-magnitude weights during issue.
module mpe_weight_sequencer
    import mpe_seq_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [BIN_LEN-1:0] ld_val,
    input  logic               ld_abs,
    input  logic [2:0]         cfg_stride,
    input  logic               start,
    input  logic               stall,
    input  logic               out_ready,
    output logic [BIN_LEN-1:0] weight_val,
    output logic               weight_abs,
    output logic [ROW_W-1:0]   weight_height,
    output logic [COL_W-1:0]   weight_width,
    output logic [2:0]         stride,
    output logic               mpe_enable,
    output logic               busy,
    output logic               done
);

    state_t             state;
    idx_t               ld_idx;
    idx_t               idx;
    logic [INF_W-1:0]   inflight;
    logic [ENTRY_W-1:0] rd_data;

    logic ld_fire;
    idx_t wr_addr;
    logic fire;
    logic dec;
    idx_t next_idx;
    logic has_next;
    idx_t first_idx;
    logic has_first;

    // start in READY takes priority over a reload beat
    assign ld_ready = (state == IDLE) || (state == READY && !start);
    assign ld_fire  = ld_valid && ld_ready;
    assign wr_addr  = (state == READY) ? '0 : ld_idx;
    assign busy     = (state == ISSUE) || (state == FLUSH) || (state == DONE);
    assign fire     = (state == ISSUE) && !stall && (inflight < INF_W'(MAX_INFLIGHT));
    assign dec      = out_ready && (inflight != '0);

    mpe_kernel_buffer u_buffer (
        .clock   (clock),
        .wr_en   (ld_fire),
        .wr_addr (wr_addr),
        .wr_data ({ld_abs, ld_val}),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

`ifdef ZERO_SKIP_EN
    logic [KSIZE-1:0] nz_mask;

    // Lookahead over the nonzero mask keeps idx on a nonzero entry, so no bubbles.
    always_comb begin
        has_next  = 1'b0;
        next_idx  = '0;
        has_first = 1'b0;
        first_idx = '0;
        for (int i = KSIZE - 1; i >= 0; i--) begin
            if (nz_mask[i]) begin
                has_first = 1'b1;
                first_idx = idx_t'(i);
                if (i > int'(idx)) begin
                    has_next = 1'b1;
                    next_idx = idx_t'(i);
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            nz_mask <= '0;
        end else if (ld_fire) begin
            nz_mask[wr_addr] <= (ld_val != '0);
        end
    end
`else
    always_comb begin
        has_next  = (idx != idx_t'(KSIZE - 1));
        next_idx  = idx + idx_t'(1);
        has_first = 1'b1;
        first_idx = '0;
    end
`endif

    // NOTE: all state and output registers use non-blocking assignments in one clocked block.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            ld_idx        <= '0;
            idx           <= '0;
            inflight      <= '0;
            weight_val    <= '0;
            weight_abs    <= 1'b0;
            weight_height <= '0;
            weight_width  <= '0;
            stride        <= '0;
            mpe_enable    <= 1'b0;
            done          <= 1'b0;
        end else begin
            mpe_enable <= 1'b0;
            done       <= 1'b0;
            inflight   <= inflight + INF_W'(fire) - INF_W'(dec);

            case (state)
                IDLE, READY: begin
                    if (state == READY && start) begin
                        stride <= cfg_stride;
                        if (has_first) begin
                            idx   <= first_idx;
                            state <= ISSUE;
                        end else begin
                            state <= FLUSH;
                        end
                    end else if (ld_fire) begin
                        if (wr_addr == idx_t'(KSIZE - 1)) begin
                            ld_idx <= '0;
                            state  <= READY;
                        end else begin
                            ld_idx <= wr_addr + idx_t'(1);
                            state  <= IDLE;
                        end
                    end
                end

                ISSUE: begin
                    if (fire) begin
                        mpe_enable    <= 1'b1;
                        weight_val    <= rd_data[BIN_LEN-1:0];
                        weight_abs    <= rd_data[BIN_LEN];
                        weight_height <= ROW_W'(int'(idx) / KW);
                        weight_width  <= COL_W'(int'(idx) % KW);
                        if (has_next) begin
                            idx <= next_idx;
                        end else begin
                            state <= FLUSH;
                        end
                    end
                end

                FLUSH: begin
                    if (inflight == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end

                DONE: begin
                    state <= READY;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpe_weight_sequencer.sv
// Scoreboard bench for mpe_weight_sequencer: stimulus pushes expected weights,
// a negedge monitor pops and compares on every mpe_enable.
module tb_mpe_weight_sequencer;
    import mpe_seq_pkg::*;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               ld_valid = 1'b0;
    logic               ld_ready;
    logic [BIN_LEN-1:0] ld_val = '0;
    logic               ld_abs = 1'b0;
    logic [2:0]         cfg_stride = '0;
    logic               start = 1'b0;
    logic               stall = 1'b0;
    logic               out_ready = 1'b0;
    logic [BIN_LEN-1:0] weight_val;
    logic               weight_abs;
    logic [ROW_W-1:0]   weight_height;
    logic [COL_W-1:0]   weight_width;
    logic [2:0]         stride;
    logic               mpe_enable;
    logic               busy;
    logic               done;

    mpe_weight_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .ld_valid      (ld_valid),
        .ld_ready      (ld_ready),
        .ld_val        (ld_val),
        .ld_abs        (ld_abs),
        .cfg_stride    (cfg_stride),
        .start         (start),
        .stall         (stall),
        .out_ready     (out_ready),
        .weight_val    (weight_val),
        .weight_abs    (weight_abs),
        .weight_height (weight_height),
        .weight_width  (weight_width),
        .stride        (stride),
        .mpe_enable    (mpe_enable),
        .busy          (busy),
        .done          (done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [BIN_LEN-1:0] val;
        logic               abs;
        logic [ROW_W-1:0]   h;
        logic [COL_W-1:0]   w;
        logic [2:0]         stride;
    } exp_t;

    exp_t exp_q[$];
    int   resp_q[$];
    int   tests = 0;
    int   failed = 0;
    int   cyc = 0;
    int   en_cnt = 0;
    int   done_cnt = 0;
    bit   resp_en = 1'b1;
    logic stall_prev = 1'b0;
    bit   have_last = 1'b0;
    logic [31:0] last_out = '0;

    logic [BIN_LEN-1:0] kern_val [KSIZE];
    logic               kern_abs [KSIZE];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Monitor: scoreboard pop, stall rule, hold rule, done accounting.
    always @(negedge clock) begin
        exp_t e;
        if (reset) begin
            have_last = 1'b0;
        end else begin
            if (mpe_enable) begin
                en_cnt++;
                check("enable_while_stalled", 32'(stall_prev), 0);
                if (exp_q.size() == 0) begin
                    check("unexpected_enable", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("weight_val", 32'(weight_val), 32'(e.val));
                    check("weight_abs", 32'(weight_abs), 32'(e.abs));
                    check("weight_height", 32'(weight_height), 32'(e.h));
                    check("weight_width", 32'(weight_width), 32'(e.w));
                    check("stride", 32'(stride), 32'(e.stride));
                end
                last_out  = 32'({weight_val, weight_abs, weight_height, weight_width});
                have_last = 1'b1;
                resp_q.push_back(cyc + 2);
            end else if (have_last) begin
                check("outputs_held", 32'({weight_val, weight_abs, weight_height, weight_width}), last_out);
            end
            if (done) begin
                done_cnt++;
                check("done_before_last_out_ready", 32'(resp_q.size()), 0);
            end
        end
        stall_prev = stall;
    end

    // MPE model: one out_ready per issued weight, two cycles after the enable.
    always @(posedge clock) begin
        cyc++;
        #1;
        out_ready = 1'b0;
        if (resp_en && resp_q.size() > 0 && resp_q[0] <= cyc) begin
            void'(resp_q.pop_front());
            out_ready = 1'b1;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic load_kernel();
        for (int i = 0; i < KSIZE; i++) begin
            ld_valid = 1'b1;
            ld_val   = kern_val[i];
            ld_abs   = kern_abs[i];
            tick();
        end
        ld_valid = 1'b0;
        check("ready_after_load_ld_ready", 32'(ld_ready), 1);
        check("ready_after_load_busy", 32'(busy), 0);
    endtask

    task automatic push_expected(input logic [2:0] s);
        exp_t e;
        for (int i = 0; i < KSIZE; i++) begin
`ifdef ZERO_SKIP_EN
            if (kern_val[i] == '0) continue;
`endif
            e.val    = kern_val[i];
            e.abs    = kern_abs[i];
            e.h      = ROW_W'(i / KW);
            e.w      = COL_W'(i % KW);
            e.stride = s;
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input logic [2:0] s);
        cfg_stride = s;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        cfg_stride = ~s;
    endtask

    task automatic wait_done(input string name);
        int d0 = done_cnt;
        int n  = 0;
        while (done_cnt == d0 && n < 200) begin
            tick();
            n++;
        end
        check({name, "_done_seen"}, 32'(done_cnt != d0), 1);
        repeat (3) tick();
        check({name, "_single_done"}, 32'(done_cnt - d0), 1);
        check({name, "_all_issued"}, 32'(exp_q.size()), 0);
        check({name, "_idle_busy"}, 32'(busy), 0);
        check({name, "_ld_ready"}, 32'(ld_ready), 1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_ld_ready"}, 32'(ld_ready), 1);
        check({name, "_enable"}, 32'(mpe_enable), 0);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_done"}, 32'(done), 0);
        check({name, "_weight"}, 32'({weight_val, weight_abs, weight_height, weight_width}), 0);
        check({name, "_stride"}, 32'(stride), 0);
    endtask

    initial begin
        int e0;
        int d0;

        repeat (2) tick();
        reset = 1'b0;
        check_reset_outputs("reset");

        // Kernel 1..9, stride 2; cfg_stride changes and a stray start mid-pass must not matter.
        for (int i = 0; i < KSIZE; i++) begin
            kern_val[i] = BIN_LEN'(i + 1);
            kern_abs[i] = 1'b0;
        end
        load_kernel();
        push_expected(3'd2);
        e0 = en_cnt;
        pulse_start(3'd2);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("pass1");
        check("pass1_enables", 32'(en_cnt - e0), 32'(KSIZE));

        // Restart without reload.
        push_expected(3'd2);
        e0 = en_cnt;
        pulse_start(3'd2);
        wait_done("pass2");
        check("pass2_enables", 32'(en_cnt - e0), 32'(KSIZE));

        // Stall on ISSUE cycles 3-5.
        push_expected(3'd3);
        pulse_start(3'd3);
        tick();
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        wait_done("stall");

        // No out_ready: issue stops at MAX_INFLIGHT until responses resume.
        resp_en = 1'b0;
        push_expected(3'd1);
        e0 = en_cnt;
        d0 = done_cnt;
        pulse_start(3'd1);
        repeat (12) tick();
        check("bp_enables_capped", 32'(en_cnt - e0), 32'(MAX_INFLIGHT));
        check("bp_no_done", 32'(done_cnt - d0), 0);
        check("bp_busy", 32'(busy), 1);
        resp_en = 1'b1;
        wait_done("backpressure");
        check("bp_total_enables", 32'(en_cnt - e0), 32'(KSIZE));

        // Sparse kernel with mixed abs flags (reload from READY).
        for (int i = 0; i < KSIZE; i++) begin
            kern_val[i] = '0;
            kern_abs[i] = 1'(i % 2);
        end
        kern_val[1] = BIN_LEN'(5);
        kern_val[4] = BIN_LEN'(7);
        load_kernel();
        push_expected(3'd4);
        e0 = en_cnt;
        pulse_start(3'd4);
        wait_done("sparse");
`ifdef ZERO_SKIP_EN
        check("sparse_enables", 32'(en_cnt - e0), 2);

        // All-zero kernel: done two cycles after start, no enables.
        for (int i = 0; i < KSIZE; i++) kern_val[i] = '0;
        load_kernel();
        e0 = en_cnt;
        pulse_start(3'd1);
        check("zero_no_done_early", 32'(done), 0);
        tick();
        check("zero_done_timing", 32'(done), 1);
        repeat (3) tick();
        check("zero_no_enable", 32'(en_cnt - e0), 0);
`else
        check("sparse_enables", 32'(en_cnt - e0), 32'(KSIZE));
`endif

        // Reset in the middle of ISSUE.
        for (int i = 0; i < KSIZE; i++) begin
            kern_val[i] = BIN_LEN'(8'h20 + i);
            kern_abs[i] = 1'(i % 3 == 0);
        end
        load_kernel();
        push_expected(3'd6);
        pulse_start(3'd6);
        repeat (3) tick();
        reset = 1'b1;
        exp_q.delete();
        resp_q.delete();
        tick();
        reset = 1'b0;
        check_reset_outputs("midreset");

        // start in IDLE is ignored.
        d0 = done_cnt;
        e0 = en_cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        check("idle_start_busy", 32'(busy), 0);
        check("idle_start_no_enable", 32'(en_cnt - e0), 0);
        check("idle_start_no_done", 32'(done_cnt - d0), 0);

        load_kernel();
        push_expected(3'd6);
        pulse_start(3'd6);
        wait_done("after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
